// File: rtl/stopwatch_bcd_pkg.sv
// Shared types and constants for the MM-SS-CC stopwatch.
// State encoding, display codes and digit range limits live here.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    LAP  = 2'd3
  } state_e;

  localparam logic [3:0] SEP_CODE = 4'hA;
  localparam logic [3:0] DIG_MAX  = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  // Six counting digits, most significant first.
  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
    logic [3:0] c1;
    logic [3:0] c0;
  } count_t;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One decade of the BCD cascade: counts 0..MAX on inc, carries out on wrap.
// carry is combinational so a full ripple completes in a single cycle.
module bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = inc && (q == MAX);

  // Wrapping on >= MAX keeps the digit in range even from an out-of-range load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= (q >= MAX) ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// Centisecond stopwatch driving an 8-digit seven-segment decoder as MM-SS-CC.
// Buttons are synchronized and edge-detected; a 4-state FSM gates counting and lap hold.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 500000,
  parameter int PRE_W    = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  output logic [3:0] decout0,
  output logic [3:0] decout1,
  output logic [3:0] decout2,
  output logic [3:0] decout3,
  output logic [3:0] decout4,
  output logic [3:0] decout5,
  output logic [3:0] decout6,
  output logic [3:0] decout7,
  output logic       running,
  output logic       ovf,
  output state_e     state_dbg
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  // Button path: bit 0 = ss, bit 1 = lap, bit 2 = clr
  logic [2:0] btn_in;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] sync3;
  logic [2:0] ev;
  logic       ev_ss;
  logic       ev_lap;
  logic       ev_clr;

  assign btn_in = {btn_clr, btn_lap, btn_ss};

  // Synchronizers reset high so a button held through reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
      sync3 <= 3'b111;
      ev    <= 3'b000;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      sync3 <= sync2;
      ev    <= sync2 & ~sync3;
    end
  end

  assign ev_ss  = ev[0];
  assign ev_lap = ev[1];
  assign ev_clr = ev[2];

  // FSM
  state_e state;
  state_e state_nxt;
  logic   counting;
  logic   hold_load;
  logic   clr_all;
  logic   running_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Priority ss > lap > clr; the losing events of a cycle are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ev_ss) state_nxt = RUN;
      end
      RUN: begin
        if (ev_ss)       state_nxt = STOP;
        else if (ev_lap) state_nxt = LAP;
      end
      LAP: begin
        if (ev_ss)       state_nxt = STOP;
        else if (ev_lap) state_nxt = RUN;
      end
      STOP: begin
        if (ev_ss)       state_nxt = RUN;
        else if (ev_clr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    counting    = (state == RUN) || (state == LAP);
    hold_load   = (state == RUN) && !ev_ss && ev_lap;
    clr_all     = (state == STOP) && !ev_ss && ev_clr;
    running_nxt = (state_nxt == RUN) || (state_nxt == LAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
    end else begin
      running <= running_nxt;
    end
  end

  assign state_dbg = state;

  // Prescaler keeps its phase across stop/resume; only clear zeroes it.
  logic [PRE_W-1:0] pre;
  logic             tick;

  assign tick = counting && (pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (clr_all) begin
      pre <= '0;
    end else if (counting) begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

  // BCD cascade
  logic [3:0] q_c0;
  logic [3:0] q_c1;
  logic [3:0] q_s0;
  logic [3:0] q_s1;
  logic [3:0] q_m0;
  logic [3:0] q_m1;
  logic [5:0] carry;

  bcd_digit #(.MAX(DIG_MAX)) u_cs0 (
    .clk(clk), .rst_n(rst_n), .clr(clr_all), .inc(tick),     .q(q_c0), .carry(carry[0])
  );
  bcd_digit #(.MAX(DIG_MAX)) u_cs1 (
    .clk(clk), .rst_n(rst_n), .clr(clr_all), .inc(carry[0]), .q(q_c1), .carry(carry[1])
  );
  bcd_digit #(.MAX(DIG_MAX)) u_s0 (
    .clk(clk), .rst_n(rst_n), .clr(clr_all), .inc(carry[1]), .q(q_s0), .carry(carry[2])
  );
  bcd_digit #(.MAX(TENS_MAX)) u_s1 (
    .clk(clk), .rst_n(rst_n), .clr(clr_all), .inc(carry[2]), .q(q_s1), .carry(carry[3])
  );
  bcd_digit #(.MAX(DIG_MAX)) u_m0 (
    .clk(clk), .rst_n(rst_n), .clr(clr_all), .inc(carry[3]), .q(q_m0), .carry(carry[4])
  );
  bcd_digit #(.MAX(TENS_MAX)) u_m1 (
    .clk(clk), .rst_n(rst_n), .clr(clr_all), .inc(carry[4]), .q(q_m1), .carry(carry[5])
  );

  count_t live;
  count_t hold;
  count_t disp;

  assign live = '{m1: q_m1, m0: q_m0, s1: q_s1, s0: q_s0, c1: q_c1, c0: q_c0};

  // Carry out of the minutes tens digit is the 59:59.99 wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (clr_all) begin
      ovf <= 1'b0;
    end else if (carry[5]) begin
      ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (hold_load) begin
      hold <= live;
    end
  end

  assign disp = (state == LAP) ? hold : live;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decout0 <= 4'd0;
      decout1 <= 4'd0;
      decout3 <= 4'd0;
      decout4 <= 4'd0;
      decout6 <= 4'd0;
      decout7 <= 4'd0;
    end else begin
      decout0 <= disp.c0;
      decout1 <= disp.c1;
      decout3 <= disp.s0;
      decout4 <= disp.s1;
      decout6 <= disp.m0;
      decout7 <= disp.m1;
    end
  end

  assign decout2 = SEP_CODE;
  assign decout5 = SEP_CODE;

endmodule

// File: doc/stopwatch_bcd.md
Name: stopwatch_bcd

Overview:
- Centisecond stopwatch that produces eight BCD/code nibbles in the format MM-SS-CC.
- Sits directly upstream of the 8-digit seven-segment decoder: decout0..decout7 connect one-to-one to that decoder's digit inputs 0..7.
- Code 4'hA renders as a dash on the display, so it is used as the separator.
- Provides start/stop, lap-freeze and clear control from push-button level inputs.

Parameters:
- TICK_DIV, 500000: clk cycles per centisecond (50 MHz / 100); must be >= 2; benches use 4.
- PRE_W, 19: prescaler counter width; must satisfy 2**PRE_W >= TICK_DIV.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_ss  in  1  start/stop request, level, active-high, asynchronous to clk, already debounced
- btn_lap  in  1  lap freeze/release request, level, active-high, already debounced
- btn_clr  in  1  clear request, level, active-high, already debounced
- decout0  out  4  centiseconds units
- decout1  out  4  centiseconds tens
- decout2  out  4  separator, constant 4'hA
- decout3  out  4  seconds units
- decout4  out  4  seconds tens (0-5)
- decout5  out  4  separator, constant 4'hA
- decout6  out  4  minutes units
- decout7  out  4  minutes tens (0-5)
- running  out  1  high in RUN or LAP
- ovf  out  1  sticky; set on wrap from 59:59.99

Behaviour:
- Reset is asynchronous, active-low; clock is a single domain.
- Reset values: state IDLE, all counters 0, prescaler 0, ovf 0, running 0, decout = {0,0,A,0,0,A,0,0} for digits 7..0.
- Button path: each btn goes through a 2-FF synchronizer, then rising-edge detect.
  - An event is one-cycle and internal.
  - A btn first sampled high at edge N produces the event at edge N+2; state and outputs update at edge N+3.
  - A held button produces exactly one event.
- States and transitions (priority per cycle: ss > lap > clr; lower-priority events that cycle are discarded):
  - IDLE: ss -> RUN; lap, clr ignored.
  - RUN: ss -> STOP; lap -> LAP (latch the current count into the display hold register); clr ignored.
  - LAP: ss -> STOP (display returns to the live count); lap -> RUN (display live); clr ignored. Counting continues throughout.
  - STOP: ss -> RUN (resume; prescaler retains its value); clr -> IDLE (all counters, prescaler and ovf set to 0); lap ignored.
- Prescaler:
  - Counts only in RUN/LAP.
  - At TICK_DIV-1 it wraps to 0 and asserts tick for one cycle.
  - First tick comes exactly TICK_DIV cycles after entering RUN from reset/clear.
- Counting on tick, BCD cascade:
  - cs units 0-9, cs tens 0-9, s units 0-9, s tens 0-5, m units 0-9, m tens 0-5.
  - A carry ripples within the same cycle.
  - 59:59.99 + tick -> 00:00.00 and ovf set to 1. ovf stays 1 until clear or reset; counting continues.
- Display:
  - decout registers load from the live counters, or from the hold register while in LAP.
  - Digits update on the edge after the counter update, so display latency is 1 cycle from the counter.
  - decout2 and decout5 are always 4'hA.
- running is registered and follows the state with no extra latency.
- Reset mid-count returns immediately (asynchronously) to reset values. Buttons held through reset deassertion generate no event, because the synchronizers reset to 1 and edge detection requires a 0->1 transition.
- No BCD digit ever holds a value above its range limit.

Decomposition:
- Shared package stopwatch_pkg:
  - state enum {IDLE, RUN, STOP, LAP}
  - constants SEP_CODE = 4'hA, DIG_MAX = 4'd9, TENS_MAX = 4'd5
- Sub-module bcd_digit: one per digit.
  - Parameter MAX.
  - Inputs clk, rst_n, clr, inc.
  - Outputs q[3:0] and carry (inc && q==MAX).
  - Six instances, chained by carry.
- Synchronizer/edge-detect logic stays inline.

Test Plan:
- Reset: after rst_n released -> decout7..0 = 0,0,A,0,0,A,0,0; running=0; ovf=0.
- TICK_DIV=4: pulse btn_ss, wait 40 ticks -> decout1=4, decout0=0, running=1. Pulse btn_ss again -> count frozen for 100 cycles.
- Lap: in RUN at 00:00.12, pulse btn_lap -> display holds 0,0,A,0,0,A,1,2 while the internal count advances. Pulse btn_lap after 30 ticks -> display shows 00:00.42.
- Carry and overflow: force the count to 59:59.99, then one tick -> 00:00.00 and ovf=1. Then stop + clear -> ovf=0, IDLE.
- Priority: btn_ss and btn_clr rise together in STOP -> RUN, count retained. btn_clr alone in RUN -> no change.
- Async reset while in RUN at 01:23.45 -> outputs at reset values within the same cycle. btn_ss held high through rst_n release -> remains IDLE.
